// File: rtl/token_scanner_pkg.sv
// token_pkg: shared codes and defaults for the token scanner slice.
//   TT_IDENT / TT_NUMBER : values driven on tok_type
//   S_IDLE / S_IDENT / S_NUM : one-hot scanner FSM states
//   LEN_W_DEF / POS_W_DEF : default widths of the length and position fields
package token_pkg;

    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned POS_W_DEF = 16;

    typedef enum logic [1:0] {
        TT_NONE   = 2'b00,
        TT_IDENT  = 2'b01,
        TT_NUMBER = 2'b10
    } tok_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_IDENT = 3'b010,
        S_NUM   = 3'b100
    } state_e;

endpackage

// File: rtl/token_scanner_if.sv
// token_scanner_if: character input stream plus token record output.
//   in_valid/in_char/in_ready : 8-bit character stream (valid/ready)
//   tok_valid/tok_ready       : token record handshake
//   tok_type/tok_len/tok_start/tok_tail_digit : token record fields
//   tok_count                 : number of records handed off (wraps)
// Modports: slave = scanner side, master = environment side.
interface token_scanner_if
    import token_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned POS_W = POS_W_DEF
);
    logic             in_valid;
    logic [7:0]       in_char;
    logic             in_ready;
    logic             tok_valid;
    logic             tok_ready;
    logic [1:0]       tok_type;
    logic [LEN_W-1:0] tok_len;
    logic [POS_W-1:0] tok_start;
    logic             tok_tail_digit;
    logic [15:0]      tok_count;

    modport slave (
        input  in_valid, in_char, tok_ready,
        output in_ready, tok_valid, tok_type, tok_len, tok_start,
               tok_tail_digit, tok_count
    );

    modport master (
        output in_valid, in_char, tok_ready,
        input  in_ready, tok_valid, tok_type, tok_len, tok_start,
               tok_tail_digit, tok_count
    );
endinterface

// File: rtl/token_scanner_char_class.sv
// char_class: combinational ASCII classifier.
//   in_char  : byte to classify
//   is_alpha : 'a'..'z' or 'A'..'Z'
//   is_digit : '0'..'9'
// Every other byte (including 8'h00) is a delimiter (both outputs low).
module char_class (
    input  logic [7:0] in_char,
    output logic       is_alpha,
    output logic       is_digit
);
    always_comb begin
        is_alpha = ((in_char >= 8'h61) && (in_char <= 8'h7A)) ||   // a..z
                   ((in_char >= 8'h41) && (in_char <= 8'h5A));     // A..Z
        is_digit =  (in_char >= 8'h30) && (in_char <= 8'h39);      // 0..9
    end
endmodule

// File: rtl/token_scanner.sv
// token_scanner: groups runs of letters/digits from a character stream
// into IDENT / NUMBER tokens and emits one record per token through a
// single-entry output register.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : token_scanner_if.slave (character input, token output,
//           tok_count). LEN_W/POS_W must match the interface instance.
module token_scanner
    import token_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned POS_W = POS_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    token_scanner_if.slave  bus
);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [POS_W-1:0] start_q, start_d;
    logic             tail_q, tail_d;
    logic [POS_W-1:0] pos_q;

    logic             out_valid_q;
    logic [1:0]       out_type_q;
    logic [LEN_W-1:0] out_len_q;
    logic [POS_W-1:0] out_start_q;
    logic             out_tail_q;
    logic [15:0]      count_q;

    logic             is_alpha, is_digit;
    logic             in_ready, accept, handoff;
    logic             emit, start_tok;
    tok_type_e        emit_type;
    logic [LEN_W-1:0] len_inc;

    char_class u_char_class (
        .in_char  (bus.in_char),
        .is_alpha (is_alpha),
        .is_digit (is_digit)
    );

    // The output register only holds one record; accepting a character is
    // only allowed when that slot is empty or retires on this edge.
    assign in_ready = ~out_valid_q | bus.tok_ready;
    assign accept   = bus.in_valid & in_ready;
    assign handoff  = out_valid_q & bus.tok_ready;
    assign len_inc  = (len_q == '1) ? len_q : len_q + LEN_ONE;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        start_d   = start_q;
        tail_d    = tail_q;
        emit      = 1'b0;
        emit_type = TT_IDENT;
        start_tok = 1'b0;
        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_alpha) begin
                        state_d   = S_IDENT;
                        start_tok = 1'b1;
                    end else if (is_digit) begin
                        state_d   = S_NUM;
                        start_tok = 1'b1;
                    end
                end
                S_IDENT: begin
                    if (is_alpha || is_digit) begin
                        len_d  = len_inc;
                        tail_d = is_digit;
                    end else begin
                        emit    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_NUM: begin
                    if (is_digit) begin
                        len_d = len_inc;
                    end else begin
                        // alpha closes the number and opens an identifier
                        // with the same character on the same edge
                        emit      = 1'b1;
                        emit_type = TT_NUMBER;
                        state_d   = is_alpha ? S_IDENT : S_IDLE;
                        start_tok = is_alpha;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (start_tok) begin
                len_d   = LEN_ONE;
                start_d = pos_q;
                tail_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            start_q <= '0;
            tail_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            start_q <= start_d;
            tail_q  <= tail_d;
            if (accept) begin
                pos_q <= pos_q + POS_W'(1);
            end
        end
    end

    // Emission records the accumulators as they stood before this
    // character; emit implies accept, so a held record is never overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_len_q   <= '0;
            out_start_q <= '0;
            out_tail_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            if (emit) begin
                out_valid_q <= 1'b1;
                out_type_q  <= emit_type;
                out_len_q   <= len_q;
                out_start_q <= start_q;
                out_tail_q  <= (emit_type == TT_IDENT) & tail_q;
            end else if (handoff) begin
                out_valid_q <= 1'b0;
            end
            if (handoff) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.tok_valid      = out_valid_q;
    assign bus.tok_type       = out_type_q;
    assign bus.tok_len        = out_len_q;
    assign bus.tok_start      = out_start_q;
    assign bus.tok_tail_digit = out_tail_q;
    assign bus.tok_count      = count_q;

endmodule
